jk_bank_arbiter: RTL and testbench

JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

---
 rtl/jk_bank_arbiter.sv | 130 +++++++++++++
 tb/tb_jk_bank_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter giving two requesters access to a JK bank.
// Define JK_READBACK_CHECK_EN to build the sticky Q readback check driving ERR.
module jk_bank_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [1:0]       OP0,
    input  logic [1:0]       OP1,
    input  logic [WIDTH-1:0] MASK0,
    input  logic [WIDTH-1:0] MASK1,
    input  logic [WIDTH-1:0] Q,
    output logic             GNT0,
    output logic             GNT1,
    output logic             DONE0,
    output logic             DONE1,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             BUSY,
    output logic             ERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DRIVE  = 2'b01,
        SETTLE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic             win_q, win_d;
    logic             ptr_q, ptr_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;

    logic             win_sel;
    logic [1:0]       op_sel;
    logic [WIDTH-1:0] mask_sel;
    logic             any_req;

    // Pick the winner: pointer breaks ties, a lone requester always wins.
    always_comb begin
        any_req  = REQ0 | REQ1;
        win_sel  = (REQ0 && REQ1) ? ptr_q : REQ1;
        op_sel   = win_sel ? OP1 : OP0;
        mask_sel = win_sel ? MASK1 : MASK0;
    end

    // Next-state logic; J/K only carry the operation into DRIVE.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        j_d     = '0;
        k_d     = '0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = DRIVE;
                    win_d   = win_sel;
                    ptr_d   = ~win_sel;
                    j_d     = op_sel[1] ? mask_sel : '0;
                    k_d     = op_sel[0] ? mask_sel : '0;
                end
            end
            DRIVE:   state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, winner, pointer and J/K registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            ptr_q   <= 1'b0;
            j_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    assign J     = j_q;
    assign K     = k_q;
    assign BUSY  = (state_q != IDLE);
    assign GNT0  = (state_q == DRIVE) && !win_q;
    assign GNT1  = (state_q == DRIVE) && win_q;
    assign DONE0 = (state_q == SETTLE) && !win_q;
    assign DONE1 = (state_q == SETTLE) && win_q;

`ifdef JK_READBACK_CHECK_EN
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] exp_q;
    logic             err_q;
    logic             mismatch;

    assign mismatch = (state_q == SETTLE) &&
                      (|((Q ^ exp_q) & mask_q));
    assign ERR = err_q | mismatch;

    // Latch the mask, predict the bank from Q seen in DRIVE, stick on error.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mask_q <= '0;
            exp_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && any_req) begin
                mask_q <= mask_sel;
            end
            if (state_q == DRIVE) begin
                exp_q <= (j_q & ~Q) | (~k_q & Q);
            end
            err_q <= err_q | mismatch;
        end
    end
`else
    logic unused_q;
    assign unused_q = ^Q;
    assign ERR      = 1'b0;
`endif

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter: vector table, corner sequences and a random
// transaction-level model for jk_bank_arbiter with a JK bank model.
module tb_jk_bank_arbiter;

    logic       clk = 1'b0;
    logic       RST_N;
    logic       REQ0, REQ1;
    logic [1:0] OP0, OP1;
    logic [7:0] MASK0, MASK1;
    logic [7:0] Q;
    logic       GNT0, GNT1, DONE0, DONE1, BUSY, ERR;
    logic [7:0] J, K;

    int checks = 0;
    int errors = 0;

    logic       ld = 1'b0;
    logic [7:0] ld_val = 8'h00;
    logic       stuck = 1'b0;

    jk_bank_arbiter #(.WIDTH(8)) dut (
        .CLK(clk), .RST_N(RST_N),
        .REQ0(REQ0), .REQ1(REQ1),
        .OP0(OP0), .OP1(OP1),
        .MASK0(MASK0), .MASK1(MASK1),
        .Q(Q),
        .GNT0(GNT0), .GNT1(GNT1),
        .DONE0(DONE0), .DONE1(DONE1),
        .J(J), .K(K),
        .BUSY(BUSY), .ERR(ERR)
    );

    always #5 clk = ~clk;

    // Bank of JK flip-flops outside the DUT.
    always @(posedge clk) begin
        if (ld)
            Q <= ld_val;
        else if (!stuck)
            Q <= (J & ~Q) | (~K & Q);
    end

    typedef struct packed {
        logic       r0;
        logic       r1;
        logic [1:0] o0;
        logic [1:0] o1;
        logic [7:0] m0;
        logic [7:0] m1;
        logic [7:0] qi;
        logic       w;
        logic [7:0] ej;
        logic [7:0] ek;
        logic [7:0] eq;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, a, e);
        end
    endtask

    task automatic load(input logic [7:0] v);
        @(negedge clk);
        ld = 1'b1;
        ld_val = v;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (GNT0 || GNT1) begin
                ok = 1'b1;
                chk("grant_latency", i, 0);
                break;
            end
        end
        if (!ok) chk("grant_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        RST_N = 1'b0;
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        RST_N = 1'b1;
    endtask

    // Operation semantics from the operation names.
    task automatic op_jk(input logic [1:0] op, input logic [7:0] m,
                         output logic [7:0] ej, output logic [7:0] ek);
        case (op)
            2'b00: begin ej = 8'h00; ek = 8'h00; end
            2'b01: begin ej = 8'h00; ek = m;     end
            2'b10: begin ej = m;     ek = 8'h00; end
            default: begin ej = m;   ek = m;     end
        endcase
    endtask

    function automatic logic [7:0] op_q(input logic [1:0] op,
                                        input logic [7:0] q,
                                        input logic [7:0] m);
        case (op)
            2'b00:   return q;
            2'b01:   return q & ~m;
            2'b10:   return q | m;
            default: return q ^ m;
        endcase
    endfunction

    task automatic txn(input vec_t v);
        bit ok;
        load(v.qi);
        REQ0 = v.r0; REQ1 = v.r1;
        OP0 = v.o0; OP1 = v.o1;
        MASK0 = v.m0; MASK1 = v.m1;
        wait_gnt(ok);
        if (ok) begin
            chk("tbl_gnt0", GNT0, !v.w);
            chk("tbl_gnt1", GNT1, v.w);
            chk("tbl_j", J, v.ej);
            chk("tbl_k", K, v.ek);
            chk("tbl_busy", BUSY, 1);
            REQ0 = 1'b0; REQ1 = 1'b0;
            OP0 = 2'($urandom); MASK0 = 8'($urandom);
            OP1 = 2'($urandom); MASK1 = 8'($urandom);
            @(negedge clk);
            chk("tbl_done0", DONE0, !v.w);
            chk("tbl_done1", DONE1, v.w);
            chk("tbl_q", Q, v.eq);
            chk("tbl_jk_off", {J, K}, 0);
            chk("tbl_err", ERR, 0);
            @(negedge clk);
            chk("tbl_idle", {BUSY, DONE0, DONE1}, 0);
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
    endtask

    initial begin
        bit         ok;
        bit         p0, p1, last, w, lose;
        logic [1:0] po0, po1, wop;
        logic [7:0] pm0, pm1, wm, ej, ek, qm;

        vt[0] = '{1'b1, 1'b0, 2'b10, 2'b00, 8'hF0, 8'h00, 8'h00,
                  1'b0, 8'hF0, 8'h00, 8'hF0};
        vt[1] = '{1'b0, 1'b1, 2'b00, 2'b11, 8'h00, 8'h0F, 8'hAA,
                  1'b1, 8'h0F, 8'h0F, 8'hA5};
        vt[2] = '{1'b1, 1'b0, 2'b01, 2'b00, 8'h3C, 8'h00, 8'hFF,
                  1'b0, 8'h00, 8'h3C, 8'hC3};
        vt[3] = '{1'b0, 1'b1, 2'b00, 2'b00, 8'h00, 8'hFF, 8'h5A,
                  1'b1, 8'h00, 8'h00, 8'h5A};
        vt[4] = '{1'b1, 1'b0, 2'b10, 2'b00, 8'h00, 8'h00, 8'h12,
                  1'b0, 8'h00, 8'h00, 8'h12};
        vt[5] = '{1'b1, 1'b1, 2'b10, 2'b01, 8'h01, 8'h80, 8'h80,
                  1'b1, 8'h00, 8'h80, 8'h00};
        vt[6] = '{1'b1, 1'b1, 2'b10, 2'b01, 8'h01, 8'h80, 8'h00,
                  1'b0, 8'h01, 8'h00, 8'h01};
        vt[7] = '{1'b1, 1'b1, 2'b10, 2'b11, 8'h01, 8'hFF, 8'h0F,
                  1'b1, 8'hFF, 8'hFF, 8'hF0};

        RST_N = 1'b0;
        REQ0 = 1'b0; REQ1 = 1'b0;
        OP0 = 2'b00; OP1 = 2'b00;
        MASK0 = 8'h00; MASK1 = 8'h00;
        ld = 1'b1; ld_val = 8'h00;
        repeat (2) @(negedge clk);
        ld = 1'b0;
        chk("reset_outs",
            {GNT0, GNT1, DONE0, DONE1, BUSY, ERR, J, K}, 0);
        RST_N = 1'b1;

        for (int i = 0; i < 8; i++) txn(vt[i]);

        // Both requesting from reset: strict alternation 0,1,0.
        do_reset();
        OP0 = 2'b00; OP1 = 2'b00;
        REQ0 = 1'b1; REQ1 = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 4)
                chk("alt_c4", {GNT1, GNT0}, 2'b10);
            else if (c % 3 == 1)
                chk("alt_c", {GNT1, GNT0}, 2'b01);
            else
                chk("alt_gap", {GNT1, GNT0}, 2'b00);
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in DRIVE aborts, then REQ1 is served normally.
        load(8'h00);
        REQ0 = 1'b1; OP0 = 2'b10; MASK0 = 8'hFF;
        @(negedge clk);
        chk("mid_gnt0", GNT0, 1);
        RST_N = 1'b0;
        #1;
        chk("mid_rst_outs",
            {GNT0, GNT1, DONE0, DONE1, BUSY, J, K}, 0);
        REQ0 = 1'b0;
        @(negedge clk);
        chk("mid_no_done", {DONE0, DONE1}, 0);
        RST_N = 1'b1;
        REQ1 = 1'b1; OP1 = 2'b10; MASK1 = 8'h01;
        @(negedge clk);
        chk("mid_gnt1", {GNT1, GNT0}, 2'b10);
        chk("mid_j", J, 8'h01);
        REQ1 = 1'b0;
        repeat (2) @(negedge clk);

        // Random transactions against a request-level model.
        do_reset();
        last = 1'b1;
        p0 = 1'b0; p1 = 1'b0;
        po0 = 0; po1 = 0; pm0 = 0; pm1 = 0;
        qm = 8'($urandom);
        load(qm);
        for (int n = 0; n < 60; n++) begin
            if (!p0 && $urandom_range(1)) begin
                p0 = 1'b1; po0 = 2'($urandom); pm0 = 8'($urandom);
            end
            if (!p1 && $urandom_range(1)) begin
                p1 = 1'b1; po1 = 2'($urandom); pm1 = 8'($urandom);
            end
            if (!p0 && !p1) begin
                p0 = 1'b1; po0 = 2'($urandom); pm0 = 8'($urandom);
            end
            REQ0 = p0; OP0 = po0; MASK0 = pm0;
            REQ1 = p1; OP1 = po1; MASK1 = pm1;
            w = (p0 && p1) ? !last : p1;
            wop = w ? po1 : po0;
            wm = w ? pm1 : pm0;
            op_jk(wop, wm, ej, ek);
            wait_gnt(ok);
            if (!ok) break;
            chk("rnd_gnt", {GNT1, GNT0}, w ? 2'b10 : 2'b01);
            chk("rnd_j", J, ej);
            chk("rnd_k", K, ek);
            last = w;
            lose = ($urandom_range(3) == 0);
            if (w) begin
                p1 = 1'b0; REQ1 = 1'b0;
                OP1 = 2'($urandom); MASK1 = 8'($urandom);
                if (lose) begin p0 = 1'b0; REQ0 = 1'b0; end
            end else begin
                p0 = 1'b0; REQ0 = 1'b0;
                OP0 = 2'($urandom); MASK0 = 8'($urandom);
                if (lose) begin p1 = 1'b0; REQ1 = 1'b0; end
            end
            qm = op_q(wop, qm, wm);
            @(negedge clk);
            chk("rnd_done", {DONE1, DONE0}, w ? 2'b10 : 2'b01);
            chk("rnd_q", Q, qm);
            chk("rnd_err", ERR, 0);
            @(negedge clk);
            chk("rnd_idle", BUSY, 0);
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        repeat (3) @(negedge clk);

        // Bank stuck at zero while setting bit 0.
        load(8'h00);
        stuck = 1'b1;
        REQ0 = 1'b1; OP0 = 2'b10; MASK0 = 8'h01;
        wait_gnt(ok);
        REQ0 = 1'b0;
        @(negedge clk);
`ifdef JK_READBACK_CHECK_EN
        chk("rb_err_settle", ERR, 1);
        repeat (3) @(negedge clk);
        chk("rb_err_held", ERR, 1);
`else
        chk("rb_err_settle", ERR, 0);
        repeat (3) @(negedge clk);
        chk("rb_err_held", ERR, 0);
`endif
        stuck = 1'b0;
        do_reset();
        #1;
        chk("rb_err_cleared", ERR, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
